rr_mux8_arbiter: RTL and testbench

//  Round-robin arbiter that shares one mux_8x1 between 8 one-bit requesters.
//  It owns the mux select, grants one requester at a time and streams the

---
 rtl/rr_mux8_arbiter_pkg.sv | 15 +
 rtl/mux_8x1.sv | 15 +
 rtl/rr_mux8_arbiter.sv | 149 ++++++++++++++
 tb/tb_rr_mux8_arbiter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/rr_mux8_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter.
//   state_t  : arbiter FSM state encoding (ST_IDLE, ST_GRANT)
//   NUM_REQ  : number of one-bit requesters sharing the mux
//   SEL_W    : width of the mux select / requester index
package rr_mux8_arbiter_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/mux_8x1.sv
// 8-to-1 single-bit multiplexer.
//   I      in   8  data inputs
//   sel    in   3  select index
//   mux_op out  1  I[sel]
module mux_8x1
    import rr_mux8_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] I,
    input  logic [SEL_W-1:0]   sel,
    output logic               mux_op
);

    assign mux_op = I[sel];

endmodule

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter sharing one mux_8x1 between 8 one-bit requesters.
// The granted requester's data bit is streamed to a single output channel.
//   clk        in   1  rising-edge clock
//   rst_n      in   1  synchronous active-low reset
//   req        in   8  level-sensitive request per requester
//   din        in   8  data bit per requester
//   gnt        out  8  registered one-hot grant, zero when idle
//   sel        out  3  registered mux select (granted index)
//   out_valid  out  1  registered, high while a grant is active
//   out_data   out  1  din[sel], forced to 0 when out_valid is low
//
// state    | meaning
// ST_IDLE  | no grant held; arbitrate from ptr whenever any req is set
// ST_GRANT | grant held for sel; release on dropped req or burst limit
module rr_mux8_arbiter
    import rr_mux8_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] din,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               out_valid,
    output logic               out_data
);

    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [SEL_W-1:0]   base;
    logic [SEL_W-1:0]   win;
    logic               mux_op;

    // First set bit of r, scanning base, base+1, ... with wrap at NUM_REQ.
    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] r,
        input logic [SEL_W-1:0]   start
    );
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] pick;
        logic             found;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = start + SEL_W'(i);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // On release the search starts just past the current owner, so the
    // owner itself is considered last.
    assign base = (state_q == ST_IDLE) ? ptr_q : (sel_q + 1'b1);
    assign win  = rr_pick(req, base);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d    = ST_GRANT;
                    sel_d      = win;
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    valid_d    = 1'b1;
                    cnt_d      = CNT_ONE;
                end
            end

            ST_GRANT: begin
                if (req[sel_q] && (cnt_q < BURST_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    ptr_d = sel_q + 1'b1;
                    if (|req) begin
                        sel_d      = win;
                        gnt_d      = '0;
                        gnt_d[win] = 1'b1;
                        valid_d    = 1'b1;
                        cnt_d      = CNT_ONE;
                    end else begin
                        // sel is left on the last owner; gnt/out_valid say idle
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    mux_8x1 u_mux (
        .I      (din),
        .sel    (sel_q),
        .mux_op (mux_op)
    );

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign out_valid = valid_q;
    assign out_data  = valid_q & mux_op;

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Directed bench for rr_mux8_arbiter (MAX_BURST=4). Each step drives inputs
// on the falling edge, queues the outputs expected after the next rising
// edge, then pops and checks them just after that edge.
module tb_rr_mux8_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] din = 8'h00;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       out_valid;
    logic       out_data;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       valid;
        logic       data;
        bit         chk_sel;
        string      tag;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    rr_mux8_arbiter #(.MAX_BURST(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .din       (din),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    task automatic check_out();
        exp_t e;
        e = sb_q.pop_front();
        n_assert++;
        assert (gnt === e.gnt) else begin
            n_fail++;
            $error("FAIL %s gnt: observed %h expected %h", e.tag, gnt, e.gnt);
        end
        n_assert++;
        assert (out_valid === e.valid) else begin
            n_fail++;
            $error("FAIL %s out_valid: observed %b expected %b", e.tag, out_valid, e.valid);
        end
        n_assert++;
        assert (out_data === e.data) else begin
            n_fail++;
            $error("FAIL %s out_data: observed %b expected %b", e.tag, out_data, e.data);
        end
        if (e.chk_sel) begin
            n_assert++;
            assert (sel === e.sel) else begin
                n_fail++;
                $error("FAIL %s sel: observed %0d expected %0d", e.tag, sel, e.sel);
            end
        end
    endtask

    task automatic step(input logic rst_v, input logic [7:0] req_v, input logic [7:0] din_v,
                        input logic [7:0] e_gnt, input logic [2:0] e_sel, input logic e_valid,
                        input bit chk_sel, input string tag);
        exp_t e;
        @(negedge clk);
        rst_n = rst_v;
        req   = req_v;
        din   = din_v;
        e.gnt     = e_gnt;
        e.sel     = e_sel;
        e.valid   = e_valid;
        e.data    = e_valid & din_v[e_sel];
        e.chk_sel = chk_sel;
        e.tag     = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        logic [7:0] g;

        // reset with all requests pending
        step(1'b0, 8'hFF, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b1, "reset0");
        step(1'b0, 8'hFF, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b1, "reset1");

        // single requester, one-cycle latency, then drop
        step(1'b1, 8'b0000_0100, 8'b0000_0100, 8'h04, 3'd2, 1'b1, 1'b1, "single_gnt");
        step(1'b1, 8'h00,        8'b0000_0100, 8'h00, 3'd2, 1'b0, 1'b0, "single_drop");

        // full round robin, 4 cycles each, no bubbles, wraps back to 0
        step(1'b0, 8'h00, 8'hA5, 8'h00, 3'd0, 1'b0, 1'b1, "rr_reset");
        for (int s = 0; s < 9; s++) begin
            g = 8'h01 << (s % 8);
            for (int k = 0; k < 4; k++)
                step(1'b1, 8'hFF, 8'hA5, g, 3'(s % 8), 1'b1, 1'b1,
                     $sformatf("rr_s%0d_c%0d", s, k + 1));
        end

        // lone requester 7: continuous grant across burst restarts
        step(1'b0, 8'h00, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b1, "lone_reset");
        for (int k = 0; k < 10; k++)
            step(1'b1, 8'h80, 8'h80, 8'h80, 3'd7, 1'b1, 1'b1, $sformatf("lone_%0d", k));
        step(1'b1, 8'h00, 8'h80, 8'h00, 3'd7, 1'b0, 1'b0, "lone_drop");
        // ptr wrapped to 0 after 7, so 0 beats 7
        step(1'b1, 8'h81, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1, "wrap_ptr0");

        // dropping own request hands over back-to-back
        step(1'b0, 8'h00, 8'h02, 8'h00, 3'd0, 1'b0, 1'b1, "drop_reset");
        step(1'b1, 8'h03, 8'h02, 8'h01, 3'd0, 1'b1, 1'b1, "drop_g0");
        step(1'b1, 8'h02, 8'h02, 8'h02, 3'd1, 1'b1, 1'b1, "drop_g1");
        for (int k = 0; k < 4; k++)
            step(1'b1, 8'h02, 8'h02, 8'h02, 3'd1, 1'b1, 1'b1, $sformatf("drop_hold_%0d", k));

        // late contention: 5 keeps its burst, then 1
        step(1'b0, 8'h00, 8'h22, 8'h00, 3'd0, 1'b0, 1'b1, "late_reset");
        step(1'b1, 8'h20, 8'h22, 8'h20, 3'd5, 1'b1, 1'b1, "late_c1");
        step(1'b1, 8'h20, 8'h22, 8'h20, 3'd5, 1'b1, 1'b1, "late_c2");
        step(1'b1, 8'h22, 8'h22, 8'h20, 3'd5, 1'b1, 1'b1, "late_c3");
        step(1'b1, 8'h22, 8'h22, 8'h20, 3'd5, 1'b1, 1'b1, "late_c4");
        step(1'b1, 8'h22, 8'h22, 8'h02, 3'd1, 1'b1, 1'b1, "late_sel1");
        for (int k = 0; k < 3; k++)
            step(1'b1, 8'h22, 8'h22, 8'h02, 3'd1, 1'b1, 1'b1, $sformatf("late_hold1_%0d", k));
        step(1'b1, 8'h22, 8'h22, 8'h20, 3'd5, 1'b1, 1'b1, "late_back5");

        // reset mid-grant clears ptr
        step(1'b0, 8'h00, 8'h40, 8'h00, 3'd0, 1'b0, 1'b1, "mid_reset0");
        step(1'b1, 8'h40, 8'h40, 8'h40, 3'd6, 1'b1, 1'b1, "mid_g6");
        step(1'b1, 8'h40, 8'h40, 8'h40, 3'd6, 1'b1, 1'b1, "mid_g6b");
        step(1'b0, 8'h40, 8'h40, 8'h00, 3'd0, 1'b0, 1'b1, "mid_rst");
        step(1'b1, 8'h41, 8'h40, 8'h01, 3'd0, 1'b1, 1'b1, "mid_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
